// File: rtl/compressor_pkg.sv
// Shared definitions for the pipelined compressor-tree adder.
// Provides the derived-size helpers (reduction level count, result width,
// row offsets into the flattened row storage) and the legal-operand-count
// check used by the top level at elaboration time.
package compressor_pkg;

  localparam int MAX_OPS = 16;

  // Number of 4:2 reduction levels needed to take NUM_OPS rows down to 2.
  function automatic int levels_f(input int num_ops);
    return $clog2(num_ops) - 1;
  endfunction

  // Width that holds the exact sum of num_ops operands of width bits.
  function automatic int out_w_f(input int width, input int num_ops);
    return width + $clog2(num_ops);
  endfunction

  // Only power-of-four-friendly trees up to MAX_OPS are supported.
  function automatic bit num_ops_ok_f(input int num_ops);
    return (num_ops == 4) || (num_ops == 8) || (num_ops == MAX_OPS);
  endfunction

  // Registered rows of every level are packed into one flat vector:
  // level 1 (num_ops/2 rows) starts at 0, level 2 follows, and so on.
  // Valid for lvl >= 1.
  function automatic int row_off_f(input int num_ops, input int lvl);
    return num_ops - 2 * (num_ops >> lvl);
  endfunction

endpackage

// File: rtl/compressor_tree_pipe_if.sv
// Stream interface of the compressor-tree adder.
//   in_valid/in_ready : operand beat handshake
//   ops               : NUM_OPS packed operands, operand i at [i*WIDTH +: WIDTH]
//   sgn               : 1 = two's complement operands, 0 = unsigned
//   out_valid/out_ready, sum : result handshake and OUT_W-bit result
// master = producer/consumer side, slave = the adder.
interface compressor_tree_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 8
) ();
  import compressor_pkg::*;

  localparam int OUT_W = out_w_f(WIDTH, NUM_OPS);

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_OPS*WIDTH-1:0] ops;
  logic                     sgn;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         sum;

  modport master (
    output in_valid, ops, sgn, out_ready,
    input  in_ready, out_valid, sum
  );

  modport slave (
    input  in_valid, ops, sgn, out_ready,
    output in_ready, out_valid, sum
  );

endinterface

// File: rtl/compress_row.sv
// One row of exact 4:2 compressor cells across W bits.
//   a, b, c, d : four W-bit input rows
//   sum_row    : W-bit sum row
//   carry_row  : W-bit carry row, already shifted left by one (top bit dropped)
// a+b+c+d == sum_row + carry_row (mod 2^W). Purely combinational.
module compress_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum_row,
  output logic [W-1:0] carry_row
);

  logic [W-1:0] cin;
  logic [W-2:0] cout_lo;
  logic [W-2:0] carry_lo;

  // cout depends only on a,b,c, so the cin chain never ripples.
  assign cin = {cout_lo, 1'b0};

  genvar gi;
  for (gi = 0; gi < W; gi++) begin : g_cell
    logic s1;
    assign s1          = a[gi] ^ b[gi] ^ c[gi];
    assign sum_row[gi] = s1 ^ d[gi] ^ cin[gi];
    // The top cell's cout/carry weigh 2^W and fall outside the modulus.
    if (gi < W - 1) begin : g_hi
      assign cout_lo[gi]  = (a[gi] & b[gi]) | (a[gi] & c[gi]) | (b[gi] & c[gi]);
      assign carry_lo[gi] = (s1 & d[gi]) | (s1 & cin[gi]) | (d[gi] & cin[gi]);
    end
  end

  assign carry_row = {carry_lo, 1'b0};

endmodule

// File: rtl/compressor_tree_pipe.sv
// Pipelined multi-operand adder: NUM_OPS operands of WIDTH bits -> OUT_W sum.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : stream interface (slave side), see compressor_tree_pipe_if
// Operands are extended (signed or unsigned) combinationally, reduced by
// LEVELS registered rows of 4:2 compressors and finished by a registered
// carry-propagate add. Latency LEVELS+1; one beat per cycle; a stall
// (result valid but not taken) freezes the whole pipe, bubbles included.
module compressor_tree_pipe
  import compressor_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 8,
  parameter int OUT_W   = out_w_f(WIDTH, NUM_OPS)
) (
  input logic                   clk,
  input logic                   rst,
  compressor_tree_pipe_if.slave bus
);

  localparam int LEVELS   = levels_f(NUM_OPS);
  localparam int NROWS    = NUM_OPS - 2;
  localparam int LAST_OFF = row_off_f(NUM_OPS, LEVELS);

  if (!num_ops_ok_f(NUM_OPS)) begin : g_bad_num_ops
    $error("compressor_tree_pipe: NUM_OPS must be 4, 8 or 16");
  end

  logic [NUM_OPS-1:0][OUT_W-1:0] ext_rows;
  logic [NROWS-1:0][OUT_W-1:0]   cmp_rows;
  logic [NROWS-1:0][OUT_W-1:0]   lvl_reg;
  logic [LEVELS:1]               vld_reg;
  logic                          out_valid_reg;
  logic [OUT_W-1:0]              sum_reg;
  logic                          stall;

  assign stall         = out_valid_reg & ~bus.out_ready;
  // Reset flushes everything, so a beat can always be offered during it.
  assign bus.in_ready  = rst | ~stall;
  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;

  genvar gi, gl;

  // Stage 0: extension to OUT_W. The sign mode is fully consumed here;
  // after extension the rows are plain modulo-2^OUT_W values, so no
  // per-level sign tag is needed to finish the sum.
  for (gi = 0; gi < NUM_OPS; gi++) begin : g_ext
    logic [WIDTH-1:0] op;
    assign op           = bus.ops[gi*WIDTH +: WIDTH];
    assign ext_rows[gi] = {{(OUT_W-WIDTH){bus.sgn & op[WIDTH-1]}}, op};
  end

  // Reduction tree: level gl turns each group of 4 rows into 2.
  for (gl = 1; gl <= LEVELS; gl++) begin : g_lvl
    localparam int OUT_OFF = row_off_f(NUM_OPS, gl);
    for (gi = 0; gi < (NUM_OPS >> (gl + 1)); gi++) begin : g_grp
      logic [OUT_W-1:0] r0, r1, r2, r3;
      if (gl == 1) begin : g_src_ops
        assign r0 = ext_rows[4*gi];
        assign r1 = ext_rows[4*gi+1];
        assign r2 = ext_rows[4*gi+2];
        assign r3 = ext_rows[4*gi+3];
      end else begin : g_src_reg
        localparam int IN_OFF = row_off_f(NUM_OPS, gl - 1);
        assign r0 = lvl_reg[IN_OFF+4*gi];
        assign r1 = lvl_reg[IN_OFF+4*gi+1];
        assign r2 = lvl_reg[IN_OFF+4*gi+2];
        assign r3 = lvl_reg[IN_OFF+4*gi+3];
      end
      compress_row #(.W(OUT_W)) u_row (
        .a         (r0),
        .b         (r1),
        .c         (r2),
        .d         (r3),
        .sum_row   (cmp_rows[OUT_OFF+2*gi]),
        .carry_row (cmp_rows[OUT_OFF+2*gi+1])
      );
    end
  end

  // Row data: no reset needed, validity is tracked separately.
  always_ff @(posedge clk) begin
    if (!stall) begin
      lvl_reg <= cmp_rows;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg       <= '0;
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
    end else if (!stall) begin
      vld_reg[1] <= bus.in_valid;
      for (int l = 2; l <= LEVELS; l++) begin
        vld_reg[l] <= vld_reg[l-1];
      end
      out_valid_reg <= vld_reg[LEVELS];
      // Load only real results so sum stays 0 after reset until one arrives.
      if (vld_reg[LEVELS]) begin
        sum_reg <= lvl_reg[LAST_OFF] + lvl_reg[LAST_OFF+1];
      end
    end
  end

endmodule

// File: tb/tb_compressor_tree_pipe.sv
// Self-checking bench for compressor_tree_pipe: directed vectors on an
// 8x8 instance plus a random stream on 4x4, 8x8 and 16x16 instances.
module tb_compressor_tree_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  compressor_tree_pipe_if #(.WIDTH(8),  .NUM_OPS(8))  bus8  ();
  compressor_tree_pipe_if #(.WIDTH(4),  .NUM_OPS(4))  bus4  ();
  compressor_tree_pipe_if #(.WIDTH(16), .NUM_OPS(16)) bus16 ();

  compressor_tree_pipe #(.WIDTH(8),  .NUM_OPS(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  compressor_tree_pipe #(.WIDTH(4),  .NUM_OPS(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  compressor_tree_pipe #(.WIDTH(16), .NUM_OPS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    longint val;
    int     t;
    int     st;
  } exp_t;

  // Directed vectors for the 8x8 instance (operand 0 in the low byte).
  string       d_name [8] = '{"uns_all_ff", "sgn_all_80", "sgn_p1_m1", "uns_all_80",
                              "sgn_all_7f", "uns_ramp", "sgn_mixed", "uns_mixed"};
  logic [63:0] d_ops  [8] = '{{8{8'hFF}}, {8{8'h80}}, 64'h0000_0000_0000_FF01, {8{8'h80}},
                              {8{8'h7F}}, 64'h0807_0605_0403_0201,
                              64'h0500_F010_FE01_7F80, 64'h0500_F010_FE01_7F80};
  logic        d_sgn  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [10:0] d_exp  [8] = '{11'h7F8, 11'h400, 11'h000, 11'h400,
                              11'h3F8, 11'h024, 11'h003, 11'h303};

  // Integer reference: extend each operand, add, reduce modulo 2^ow.
  function automatic longint ref_sum(input logic [255:0] ops, input logic s,
                                     input int n, input int w, input int ow);
    longint acc;
    longint v;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      v = longint'((ops >> (i * w)) & ((256'(1) << w) - 256'(1)));
      if (s && v[w-1]) v = v - (64'sd1 << w);
      acc = acc + v;
    end
    return acc & ((64'sd1 << ow) - 1);
  endfunction

  task automatic idle_all();
    bus8.in_valid = 1'b0;  bus8.out_ready = 1'b1;  bus8.ops = '0;  bus8.sgn = 1'b0;
    bus4.in_valid = 1'b0;  bus4.out_ready = 1'b1;  bus4.ops = '0;  bus4.sgn = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.ops = '0; bus16.sgn = 1'b0;
  endtask

  // Sends one beat into the idle 8x8 pipe and reports the result and the
  // number of cycles until out_valid (-1 on timeout).
  task automatic run_beat(input logic [63:0] ops, input logic s,
                          output logic [10:0] got, output int lat);
    @(negedge clk);
    bus8.ops = ops; bus8.sgn = s; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = -1;
    got = '0;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if (bus8.out_valid) begin
        lat = i;
        got = bus8.sum;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    idle_all();
    bus8.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (bus8.in_ready !== 1'b1) begin
      n_miss++; $display("FAIL reset_in_ready_during got=%b want=1", bus8.in_ready);
    end
    rst = 1'b0;
    bus8.out_ready = 1'b1;
    @(negedge clk); #1;
    n_vec++;
    if (bus8.out_valid !== 1'b0 || bus8.sum !== 11'h000) begin
      n_miss++; $display("FAIL reset_state8 got valid=%b sum=%h want valid=0 sum=000", bus8.out_valid, bus8.sum);
    end
    n_vec++;
    if (bus4.out_valid !== 1'b0 || bus16.out_valid !== 1'b0 || bus16.sum !== 20'h0) begin
      n_miss++; $display("FAIL reset_state_other got v4=%b v16=%b sum16=%h want 0 0 0", bus4.out_valid, bus16.out_valid, bus16.sum);
    end
    n_vec++;
    if (bus8.in_ready !== 1'b1) begin
      n_miss++; $display("FAIL reset_in_ready_after got=%b want=1", bus8.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [10:0] got;
    int          lat;
    for (int v = 0; v < 8; v++) begin
      run_beat(d_ops[v], d_sgn[v], got, lat);
      n_vec++;
      if (got !== d_exp[v]) begin
        n_miss++; $display("FAIL %s sum got=%h want=%h", d_name[v], got, d_exp[v]);
      end
      n_vec++;
      if (lat != 3) begin
        n_miss++; $display("FAIL %s latency got=%0d want=3", d_name[v], lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      bus8.out_ready = 1'b1;
      bus8.sgn       = 1'b0;
      bus8.in_valid  = (t < 10);
      bus8.ops       = {8{8'(t)}};
      #1;
      if (bus8.out_valid) begin
        n_vec++;
        if (bus8.sum !== 11'(8 * k) || t != k + 3) begin
          n_miss++; $display("FAIL b2b_result%0d got sum=%0d cycle=%0d want sum=%0d cycle=%0d", k, bus8.sum, t, 8 * k, k + 3);
        end
        k++;
      end
    end
    bus8.in_valid = 1'b0;
    n_vec++;
    if (k != 10) begin
      n_miss++; $display("FAIL b2b_count got=%0d want=10", k);
    end
  endtask

  task automatic test_backpressure();
    longint q[$];
    int nb = 0;
    int ng = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      bus8.out_ready = (t >= 8);
      bus8.in_valid  = (nb < 4);
      bus8.sgn       = 1'b0;
      bus8.ops       = {8{8'(10 + nb)}};
      #1;
      if (t < 8) begin
        n_vec++;
        if (bus8.in_ready !== (t < 3)) begin
          n_miss++; $display("FAIL bp_in_ready cycle=%0d got=%b want=%b", t, bus8.in_ready, (t < 3));
        end
      end
      if (t >= 3 && t < 8) begin
        n_vec++;
        if (bus8.out_valid !== 1'b1 || bus8.sum !== 11'd80) begin
          n_miss++; $display("FAIL bp_hold cycle=%0d got valid=%b sum=%0d want valid=1 sum=80", t, bus8.out_valid, bus8.sum);
        end
      end
      if (bus8.out_valid && bus8.out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_miss++; $display("FAIL bp_drain unexpected result sum=%0d want none", bus8.sum);
        end else if (64'(bus8.sum) !== q[0]) begin
          n_miss++; $display("FAIL bp_drain%0d got=%0d want=%0d", ng, bus8.sum, q[0]);
        end
        if (q.size() != 0) void'(q.pop_front());
        ng++;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        q.push_back(longint'(8 * (10 + nb)));
        nb++;
      end
    end
    bus8.in_valid = 1'b0;
    n_vec++;
    if (ng != 4 || q.size() != 0) begin
      n_miss++; $display("FAIL bp_count got=%0d left=%0d want 4 and 0", ng, q.size());
    end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    for (int t = 0; t < 11; t++) begin
      @(negedge clk);
      bus8.sgn       = 1'b0;
      bus8.in_valid  = (t < 2);
      bus8.ops       = (t == 0) ? {8{8'h11}} : {8{8'h22}};
      bus8.out_ready = (t >= 4);
      rst            = (t == 3);
      #1;
      if (t == 3) begin
        n_vec++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b1) begin
          n_miss++; $display("FAIL rstmid_pre got in_ready=%b valid=%b want 1 1", bus8.in_ready, bus8.out_valid);
        end
      end
      if (t == 4) begin
        n_vec++;
        if (bus8.out_valid !== 1'b0 || bus8.sum !== 11'h000) begin
          n_miss++; $display("FAIL rstmid_clear got valid=%b sum=%h want 0 000", bus8.out_valid, bus8.sum);
        end
      end
      if (t >= 4 && bus8.out_valid) stale++;
    end
    rst = 1'b0;
    bus8.in_valid = 1'b0;
    n_vec++;
    if (stale != 0) begin
      n_miss++; $display("FAIL rstmid_stale got=%0d results want=0", stale);
    end
  endtask

  task automatic test_random();
    exp_t q4[$], q8[$], q16[$];
    exp_t e;
    int st4 = 0, st8 = 0, st16 = 0;
    logic [255:0] r;
    bit live;
    for (int t = 0; t < 312; t++) begin
      live = (t < 300);
      @(negedge clk);
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
      bus4.ops  = r[15:0];   bus4.sgn  = 1'($urandom_range(0, 1));
      bus8.ops  = r[127:64]; bus8.sgn  = 1'($urandom_range(0, 1));
      bus16.ops = r;         bus16.sgn = 1'($urandom_range(0, 1));
      bus4.in_valid   = live && ($urandom_range(0, 3) != 0);
      bus8.in_valid   = live && ($urandom_range(0, 3) != 0);
      bus16.in_valid  = live && ($urandom_range(0, 3) != 0);
      bus4.out_ready  = !live || ($urandom_range(0, 9) < 7);
      bus8.out_ready  = !live || ($urandom_range(0, 9) < 7);
      bus16.out_ready = !live || ($urandom_range(0, 9) < 7);
      #1;
      // 4x4 instance, latency 2
      if (bus4.out_valid && bus4.out_ready) begin
        n_vec++;
        if (q4.size() == 0) begin
          n_miss++; $display("FAIL rnd4 unexpected result sum=%h", bus4.sum);
        end else begin
          e = q4.pop_front();
          if (64'(bus4.sum) !== e.val || t - e.t != 2 + st4 - e.st) begin
            n_miss++; $display("FAIL rnd4 got sum=%h lat=%0d want sum=%h lat=%0d", bus4.sum, t - e.t, e.val, 2 + st4 - e.st);
          end
        end
      end
      if (bus4.in_valid && bus4.in_ready) begin
        e.val = ref_sum(256'(bus4.ops), bus4.sgn, 4, 4, 6); e.t = t; e.st = st4; q4.push_back(e);
      end
      if (bus4.out_valid && !bus4.out_ready) st4++;
      // 8x8 instance, latency 3
      if (bus8.out_valid && bus8.out_ready) begin
        n_vec++;
        if (q8.size() == 0) begin
          n_miss++; $display("FAIL rnd8 unexpected result sum=%h", bus8.sum);
        end else begin
          e = q8.pop_front();
          if (64'(bus8.sum) !== e.val || t - e.t != 3 + st8 - e.st) begin
            n_miss++; $display("FAIL rnd8 got sum=%h lat=%0d want sum=%h lat=%0d", bus8.sum, t - e.t, e.val, 3 + st8 - e.st);
          end
        end
      end
      if (bus8.in_valid && bus8.in_ready) begin
        e.val = ref_sum(256'(bus8.ops), bus8.sgn, 8, 8, 11); e.t = t; e.st = st8; q8.push_back(e);
      end
      if (bus8.out_valid && !bus8.out_ready) st8++;
      // 16x16 instance, latency 4
      if (bus16.out_valid && bus16.out_ready) begin
        n_vec++;
        if (q16.size() == 0) begin
          n_miss++; $display("FAIL rnd16 unexpected result sum=%h", bus16.sum);
        end else begin
          e = q16.pop_front();
          if (64'(bus16.sum) !== e.val || t - e.t != 4 + st16 - e.st) begin
            n_miss++; $display("FAIL rnd16 got sum=%h lat=%0d want sum=%h lat=%0d", bus16.sum, t - e.t, e.val, 4 + st16 - e.st);
          end
        end
      end
      if (bus16.in_valid && bus16.in_ready) begin
        e.val = ref_sum(bus16.ops, bus16.sgn, 16, 16, 20); e.t = t; e.st = st16; q16.push_back(e);
      end
      if (bus16.out_valid && !bus16.out_ready) st16++;
    end
    idle_all();
    n_vec++;
    if (q4.size() != 0 || q8.size() != 0 || q16.size() != 0) begin
      n_miss++; $display("FAIL rnd_drain left q4=%0d q8=%0d q16=%0d want 0 0 0", q4.size(), q8.size(), q16.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/compressor_tree_pipe.md
Name: compressor_tree_pipe

Overview:
- Parametrised, pipelined multi-operand adder that reduces NUM_OPS operands of WIDTH bits to one sum.
- Built from rows of exact 4:2 compressor cells (a,b,c,d,cin -> sum,carry,cout), with a register after every reduction level, followed by a registered final carry-propagate add.
- Successor to the single combinational 4:2 cell: it adds width and operand-count generalisation, a signed/unsigned mode, and a valid/ready stream handshake with backpressure.
- Sits in the datapath as the partial-product / multi-operand summation block.

Parameters:
- WIDTH, 8, bit width of each input operand.
- NUM_OPS, 8, number of operands. Legal values are 4, 8 and 16; any other value is an elaboration error.
- OUT_W, WIDTH+$clog2(NUM_OPS), result width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- ops  in  NUM_OPS*WIDTH  packed operands; operand i occupies bits [i*WIDTH +: WIDTH].
- sgn  in  1  1 = operands are two's complement, 0 = unsigned. Sampled with the beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  OUT_W  result, two's complement when the beat's sgn=1.

Behaviour:
- Reset (synchronous, active-high):
  - All pipeline valid bits, out_valid and sum clear to 0 on the first clk edge with rst=1.
  - in_ready is 1 during and after reset.
  - Data registers other than sum need not be reset.
- Operand extension: each operand is extended to OUT_W at stage 0 — sign-extended when sgn=1, zero-extended when sgn=0.
- Reduction levels:
  - LEVELS = log2(NUM_OPS)-1 compressor levels.
  - Each level maps groups of 4 rows to 2 rows (sum row, carry row shifted left by 1).
  - cout of bit k feeds cin of bit k+1; cin of bit 0 is 0.
  - Every level is registered.
- Final stage: an OUT_W-bit add of the last 2 rows, registered into sum.
- Width rule: all arithmetic is modulo 2^OUT_W. Bits carried out above OUT_W are discarded; the result is exact for every legal input.
- Latency: LEVELS+1 cycles from an accepted beat to out_valid. That is 2 cycles for NUM_OPS=4, 3 for 8, and 4 for 16.
- Throughput: 1 beat per cycle when out_ready=1.
- Handshake:
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - While stall=1, every pipeline register, valid bit and sgn tag holds its value, and sum and out_valid are stable.
  - Bubbles are not collapsed during a stall.
- Each stage carries its own valid and sgn tag. A cycle with in_valid=0 and no stall injects a bubble (valid=0).
- Simultaneous events: when the output transfers and a new beat is accepted in the same cycle, both take effect; there is no loss and no duplication.
- Reset mid-operation: all in-flight beats are discarded and out_valid=0 after the reset edge. No partial result is ever presented.
- sum is don't-care when out_valid=0, except that it is 0 after reset.

Decomposition:
- Shared package compressor_pkg holds:
  - function levels_f(NUM_OPS) returning LEVELS;
  - function out_w_f(WIDTH, NUM_OPS);
  - localparam MAX_OPS=16;
  - the legal-NUM_OPS check.
- Sub-module compress_row, parameter W:
  - Inputs: four W-bit rows.
  - Outputs: a W-bit sum row and a W-bit carry row, carry already shifted left by 1 with the top bit dropped.
  - Combinational; the internal cin/cout chain uses the existing 4:2 cell equations.
  - Instantiated NUM_OPS/4 + NUM_OPS/8 + … times via generate.
- The top level owns all registers, the stall logic and the final adder.

Test Plan:
- NUM_OPS=8, WIDTH=8, sgn=0, all operands 8'hFF, out_ready=1 -> out_valid rises exactly 3 cycles after acceptance, sum = 11'h7F8 (2040).
- Same configuration, sgn=1, all operands 8'h80 -> sum = 11'h400 (-1024). Operands {8'h01, 8'hFF, 0, 0, 0, 0, 0, 0} with sgn=1 -> sum = 11'h000.
- Back-to-back stream of 10 beats, operand i = beat index, out_ready=1 -> 10 consecutive results, each 8*index, in order with no gaps.
- Backpressure: stream beats while out_ready=0 -> in_ready drops once the first result is valid. sum and out_valid hold for 5 cycles. Raising out_ready drains every result once, in order.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 and sum=0 the next cycle, and no stale result ever appears.
- Random regression, NUM_OPS in {4, 8, 16}, WIDTH in {4, 8, 16}, random sgn, random out_ready -> every sum equals the reference sum modulo 2^OUT_W, and latency is LEVELS+1 cycles plus stall cycles.
